accum_stage: RTL and testbench
==============================

// Module: accum_stage
//
// PURPOSE
//   Sequential accumulator sitting directly downstream of the 4-bit ripple
//   adder: consumes one adder result per handshake (in_data = {c_out, s})
//   and sums COUNT results into a frame total. Presents the total with a
//   sticky overflow flag on a valid/ready output, then starts the next frame.
//
// PARAMETERS
//   WIDTH      5   input sample width ({c_out, s} of the 4-bit adder)
//   ACC_WIDTH  8   accumulator / out_sum width (>= WIDTH)
//   COUNT      16  accepted samples per frame (>= 1)
//
// PORTS
//   clk        in   1          single clock, all state on posedge
//   rst        in   1          synchronous reset, active-high
//   in_valid   in   1          upstream sample valid
//   in_ready   out  1          block accepts sample this cycle
//   in_data    in   WIDTH      unsigned sample, zero-extended to ACC_WIDTH
//   out_valid  out  1          frame total valid
//   out_ready  in   1          downstream takes total this cycle
//   out_sum    out  ACC_WIDTH  frame total
//   out_ovf    out  1          sticky: frame sum exceeded 2^ACC_WIDTH-1
//
// BEHAVIOUR
//   - Reset (rst=1 at posedge): state=ACCUM, acc=0, cnt=0, ovf=0;
//     out_valid=0, out_sum=0, out_ovf=0; in_ready=0 while rst is high.
//   - FSM, 2 states:
//     ACCUM: in_ready=1, out_valid=0. Handshake = in_valid & in_ready.
//       On handshake: {carry, acc} <= acc + zext(in_data) (ACC_WIDTH+1 bits);
//       ovf <= ovf | carry; cnt <= cnt+1. Cycles without in_valid: no change.
//       Handshake with cnt==COUNT-1 -> HOLD; that sample is included.
//     HOLD: in_ready=0, out_valid=1, out_sum=acc, out_ovf=ovf, all stable.
//       out_ready=1 -> ACCUM next cycle with acc=0, cnt=0, ovf=0.
//       out_ready=0 -> stay, outputs held indefinitely.
//   - Latency: out_valid rises the cycle after the COUNT-th input handshake.
//   - Min frame period COUNT+1 cycles (no input accepted in HOLD cycle,
//     including the cycle out_ready is high).
//   - in_valid in HOLD is ignored (upstream must hold data until in_ready).
//   - cnt width = clog2(COUNT) (1 bit min); cnt never exceeds COUNT-1.
//   - Wrap mode: acc wraps modulo 2^ACC_WIDTH; ovf records any wrap.
//   - rst mid-frame or in HOLD: partial sum discarded, back to reset state.
//
// CONFIGURATION
//   ACCUM_SATURATE_EN defined: on carry, acc <= {ACC_WIDTH{1'b1}} and
//     stays there for rest of frame; ovf set as in wrap mode.
//   ACCUM_SATURATE_EN undefined: modulo wrap as above (default).
//
// TESTING (COUNT=4, ACC_WIDTH=8 unless noted)
//   1. rst 2 cycles, then samples 3,5,7,9 back-to-back -> out_valid 1 cycle
//      after 4th handshake, out_sum=24, out_ovf=0; out_ready=1 -> next frame.
//   2. COUNT=16, sixteen samples of 31 -> wrap: out_sum=240, out_ovf=1;
//      with ACCUM_SATURATE_EN: out_sum=255, out_ovf=1.
//   3. in_valid toggled 1,0,0,1,0,1,1 with data 2 -> only 4 handshakes
//      counted, out_sum=8; bubbles do not advance cnt.
//   4. HOLD with out_ready=0 for 5 cycles while in_valid=1 -> out_sum/out_ovf
//      stable, in_ready=0, no sample lost; accepted first cycle back in ACCUM.
//   5. rst pulse after 2 samples (10,10), then 1,1,1,1 -> out_sum=4, ovf=0.
//   6. Drive from adder instance over all 512 {a,b,c_in} vectors, COUNT=4 ->
//      each out_sum equals scoreboard sum of 4 consecutive a+b+c_in values.

Source files
------------

// File: rtl/accum_stage.sv
// ============================================================================
//  Module      : accum_stage
//  Description : Frame accumulator behind the 4-bit ripple adder; sums COUNT
//                samples per frame and presents the total with a sticky
//                overflow flag. Define ACCUM_SATURATE_EN to saturate instead
//                of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module accum_stage #(
   parameter int WIDTH     = 5,
   parameter int ACC_WIDTH = 8,
   parameter int COUNT     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] out_sum,
   output logic                 out_ovf
);

   localparam int                CNT_W    = (COUNT > 1) ? $clog2(COUNT) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(COUNT - 1);
   localparam int                PAD_W    = ACC_WIDTH + 1 - WIDTH;

   typedef enum logic [0:0] {
      ST_ACCUM = 1'b0,
      ST_HOLD  = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic [ACC_WIDTH-1:0]   acc_q,   acc_d;
   logic [CNT_W-1:0]       cnt_q,   cnt_d;
   logic                   ovf_q,   ovf_d;

   logic [ACC_WIDTH:0]     sum_w;
   logic                   hs_w;

   // One extra bit on the adder exposes the carry used for the overflow flag.
   assign sum_w = {1'b0, acc_q} + {{PAD_W{1'b0}}, in_data};

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_sum   = '0;
      out_ovf   = 1'b0;
      hs_w      = 1'b0;

      case (state_q)
         ST_ACCUM: begin
            in_ready = ~rst;
            hs_w     = in_valid & ~rst;
            if (hs_w) begin
               ovf_d = ovf_q | sum_w[ACC_WIDTH];
`ifdef ACCUM_SATURATE_EN
               acc_d = sum_w[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum_w[ACC_WIDTH-1:0];
`else
               acc_d = sum_w[ACC_WIDTH-1:0];
`endif
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  state_d = ST_HOLD;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end

         ST_HOLD: begin
            out_valid = 1'b1;
            out_sum   = acc_q;
            out_ovf   = ovf_q;
            if (out_ready) begin
               state_d = ST_ACCUM;
               acc_d   = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end
         end

         default: begin
            state_d = ST_ACCUM;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_ACCUM;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_accum_stage.sv
// ============================================================================
//  Module      : tb_accum_stage
//  Description : Directed scoreboard bench for accum_stage (COUNT=4 and 16).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_accum_stage;

   localparam int W  = 5;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, out_valid, out_ready, out_ovf;
   logic [W-1:0]  in_data;
   logic [AW-1:0] out_sum;

   logic          v16, rdy16, ov16, ordy16, ovf16;
   logic [W-1:0]  d16;
   logic [AW-1:0] sum16;

   always #5 clk = ~clk;

   accum_stage #(.WIDTH(W), .ACC_WIDTH(AW), .COUNT(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_ovf   (out_ovf)
   );

   accum_stage #(.WIDTH(W), .ACC_WIDTH(AW), .COUNT(16)) dut16 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (v16),
      .in_ready  (rdy16),
      .in_data   (d16),
      .out_valid (ov16),
      .out_ready (ordy16),
      .out_sum   (sum16),
      .out_ovf   (ovf16)
   );

`ifdef ACCUM_SATURATE_EN
   bit sat = 1'b1;
`else
   bit sat = 1'b0;
`endif

   int            checks   = 0;
   int            failures = 0;
   logic [AW:0]   exp_q[$];
   logic [AW:0]   exp_e;
   int            m_cnt;
   logic [AW-1:0] m_acc;
   logic          m_ovf;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic fail_now(input string tag);
      checks++;
      failures++;
      $error("FAIL %s observed=timeout expected=event", tag);
   endtask

   task automatic model_clear();
      m_cnt = 0;
      m_acc = '0;
      m_ovf = 1'b0;
   endtask

   // Reference: ACC_WIDTH+1 bit add, wrap or saturate, push total every 4 samples.
   task automatic model_add(input logic [W-1:0] d);
      logic [AW:0] s;
      s     = {1'b0, m_acc} + {{(AW+1-W){1'b0}}, d};
      m_ovf = m_ovf | s[AW];
      m_acc = (sat && s[AW]) ? {AW{1'b1}} : s[AW-1:0];
      m_cnt++;
      if (m_cnt == 4) begin
         exp_q.push_back({m_ovf, m_acc});
         model_clear();
      end
   endtask

   task automatic cycle(input logic v, input logic [W-1:0] d, output bit hs);
      in_valid = v;
      in_data  = d;
      @(negedge clk);
      hs = v && (in_ready === 1'b1);
      @(posedge clk);
      #1;
      if (hs) model_add(d);
   endtask

   task automatic send(input logic [W-1:0] d);
      bit hs;
      int n;
      n = 0;
      do begin
         cycle(1'b1, d, hs);
         n++;
      end while (!hs && n < 50);
      if (!hs) fail_now("send_timeout");
      in_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            fail_now("unexpected_output");
         end else begin
            exp_e = exp_q.pop_front();
            check("out_sum", 32'(out_sum), 32'(exp_e[AW-1:0]));
            check("out_ovf", 32'(out_ovf), 32'(exp_e[AW]));
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit hs;
      bit done;
      int n;
      logic [3:0] a, b;
      logic       ci;

      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      v16 = 1'b0; d16 = '0; ordy16 = 1'b1;
      model_clear();

      // Reset state
      @(negedge clk);
      check("rst_in_ready",  32'(in_ready),  0);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_sum",   32'(out_sum),   0);
      check("rst_out_ovf",   32'(out_ovf),   0);
      check("rst_in_ready16", 32'(rdy16),    0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Back-to-back frame 3,5,7,9 -> 24
      send(5'd3); send(5'd5); send(5'd7); send(5'd9);
      @(negedge clk);
      check("latency_out_valid", 32'(out_valid), 1);
      check("hold_in_ready", 32'(in_ready), 0);
      @(posedge clk); #1;

      // Bubbles: only valid cycles count
      cycle(1'b1, 5'd2, hs); cycle(1'b0, 5'd2, hs); cycle(1'b0, 5'd2, hs);
      cycle(1'b1, 5'd2, hs); cycle(1'b0, 5'd2, hs); cycle(1'b1, 5'd2, hs);
      cycle(1'b1, 5'd2, hs);
      in_valid = 1'b0;
      @(negedge clk);
      check("bubble_out_valid", 32'(out_valid), 1);
      @(posedge clk); #1;

      // Backpressure: HOLD stalls with in_valid high
      out_ready = 1'b0;
      send(5'd31); send(5'd31); send(5'd31); send(5'd20);
      in_valid = 1'b1; in_data = 5'd7;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_out_valid", 32'(out_valid), 1);
         check("stall_in_ready",  32'(in_ready),  0);
         check("stall_out_sum",   32'(out_sum),   113);
         check("stall_out_ovf",   32'(out_ovf),   0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("release_in_ready", 32'(in_ready), 0);
      @(posedge clk); #1;
      cycle(1'b1, 5'd7, hs);
      check("accept_first_cycle", 32'(hs), 1);
      send(5'd1); send(5'd1); send(5'd1);

      // Reset mid-frame discards partial sum
      send(5'd10); send(5'd10);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_in_ready", 32'(in_ready), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      model_clear();
      @(negedge clk);
      check("postrst_out_valid", 32'(out_valid), 0);
      @(posedge clk); #1;
      send(5'd1); send(5'd1); send(5'd1); send(5'd1);

      // Adder-driven sweep over all {c_in, b, a}
      for (int v = 0; v < 512; v++) begin
         a  = v[3:0];
         b  = v[7:4];
         ci = v[8];
         send(5'(a) + 5'(b) + 5'(ci));
      end
      @(negedge clk);
      @(posedge clk); #1;

      // COUNT=16 overflow: sixteen samples of 31
      v16 = 1'b1; d16 = 5'd31;
      n = 0; done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (ov16) done = 1'b1;
         else begin
            if (rdy16) n++;
            @(posedge clk); #1;
         end
      end
      v16 = 1'b0;
      if (!done) fail_now("count16_timeout");
      else begin
         check("count16_handshakes", 32'(n), 16);
         check("count16_sum", 32'(sum16), sat ? 255 : 240);
         check("count16_ovf", 32'(ovf16), 1);
      end
      @(posedge clk); #1;
      @(negedge clk);
      check("count16_released", 32'(ov16), 0);

      check("scoreboard_drain", 32'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
